decode_queue: RTL and testbench

- Parametrised successor to the single-entry decoder. Adds a DEPTH-entry instruction buffer between InstFetch and dispatch.
- Decodes the head entry for RV32I, with RV32M optional.
- Dispatches to ROB, RS and LSB with per-target back-pressure, so fetch no longer stalls on every full cycle.
- Flushes the whole buffer on branch mispredict.

---
 rtl/decode_queue.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// DEPTH-entry instruction buffer between fetch and dispatch, decoding the head for RV32I.
// Define DECODE_RV32M_EN to also decode RV32M (MUL..REMU, ids 40-47).
module decode_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              in_isjump,
    input  logic [31:0]       in_jump_pc,
    input  logic              rob_full,
    input  logic              rs_full,
    input  logic              lsb_full,
    output logic              dsp_valid,
    output logic              dsp_to_rs,
    output logic              dsp_to_lsb,
    output logic              dsp_illegal,
    output logic [5:0]        dsp_opcode_id,
    output logic [4:0]        dsp_rd,
    output logic [4:0]        dsp_rs1,
    output logic [4:0]        dsp_rs2,
    output logic [31:0]       dsp_imm,
    output logic              dsp_isjump,
    output logic [31:0]       dsp_jump_pc,
    output logic [ADDR_W:0]   count
);

    localparam logic [5:0] ID_LUI   = 6'd1;
    localparam logic [5:0] ID_AUIPC = 6'd2;
    localparam logic [5:0] ID_JAL   = 6'd3;
    localparam logic [5:0] ID_JALR  = 6'd4;
    localparam logic [5:0] ID_BEQ   = 6'd5;
    localparam logic [5:0] ID_BNE   = 6'd6;
    localparam logic [5:0] ID_BLT   = 6'd7;
    localparam logic [5:0] ID_BGE   = 6'd8;
    localparam logic [5:0] ID_BLTU  = 6'd9;
    localparam logic [5:0] ID_BGEU  = 6'd10;
    localparam logic [5:0] ID_LB    = 6'd11;
    localparam logic [5:0] ID_LH    = 6'd12;
    localparam logic [5:0] ID_LW    = 6'd13;
    localparam logic [5:0] ID_LBU   = 6'd14;
    localparam logic [5:0] ID_LHU   = 6'd15;
    localparam logic [5:0] ID_SB    = 6'd16;
    localparam logic [5:0] ID_SH    = 6'd17;
    localparam logic [5:0] ID_SW    = 6'd18;
    localparam logic [5:0] ID_ADDI  = 6'd19;
    localparam logic [5:0] ID_SLTI  = 6'd20;
    localparam logic [5:0] ID_SLTIU = 6'd21;
    localparam logic [5:0] ID_XORI  = 6'd22;
    localparam logic [5:0] ID_ORI   = 6'd23;
    localparam logic [5:0] ID_ANDI  = 6'd24;
    localparam logic [5:0] ID_SLLI  = 6'd25;
    localparam logic [5:0] ID_SRLI  = 6'd26;
    localparam logic [5:0] ID_SRAI  = 6'd27;
    localparam logic [5:0] ID_ADD   = 6'd28;
    localparam logic [5:0] ID_SUB   = 6'd29;
    localparam logic [5:0] ID_SLL   = 6'd30;
    localparam logic [5:0] ID_SLT   = 6'd31;
    localparam logic [5:0] ID_SLTU  = 6'd32;
    localparam logic [5:0] ID_XOR   = 6'd33;
    localparam logic [5:0] ID_SRL   = 6'd34;
    localparam logic [5:0] ID_SRA   = 6'd35;
    localparam logic [5:0] ID_OR    = 6'd36;
    localparam logic [5:0] ID_AND   = 6'd37;
`ifdef DECODE_RV32M_EN
    localparam logic [5:0] ID_MUL   = 6'd40;
`endif

    localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CONE = 1;
    localparam logic [ADDR_W-1:0] PONE = 1;

    logic [31:0]       r_instr  [DEPTH];
    logic              r_isjump [DEPTH];
    logic [31:0]       r_jpc    [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;

    logic        w_push;
    logic        w_pop;
    logic        w_nonempty;
    logic [31:0] w_instr;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_sh;
    logic [5:0]  w_op;
    logic        w_rs;
    logic        w_lsb;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;

    assign w_nonempty = (r_count != '0);
    assign in_ready   = (r_count != FULL);
    assign count      = r_count;
    assign w_push     = in_valid && in_ready && rdy && !jump_wrong;
    assign w_pop      = dsp_valid;

    assign w_instr  = r_instr[r_rd_ptr];
    assign w_opc    = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];
    assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25],
                       w_instr[11:7]};
    assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                       w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u  = {w_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31],
                       w_instr[19:12], w_instr[20],
                       w_instr[30:21], 1'b0};
    assign w_imm_sh = {27'b0, w_instr[24:20]};

    always_comb begin
        w_op  = '0;
        w_rs  = 1'b0;
        w_lsb = 1'b0;
        w_rd  = '0;
        w_rs1 = '0;
        w_rs2 = '0;
        w_imm = '0;
        case (w_opc)
            7'd55: begin
                w_op  = ID_LUI;
                w_rd  = w_instr[11:7];
                w_imm = w_imm_u;
            end
            7'd23: begin
                w_op  = ID_AUIPC;
                w_rd  = w_instr[11:7];
                w_imm = w_imm_u;
            end
            7'd111: begin
                w_op  = ID_JAL;
                w_rd  = w_instr[11:7];
                w_imm = w_imm_j;
            end
            7'd103: begin
                if (w_f3 == 3'd0) w_op = ID_JALR;
                w_rs  = 1'b1;
                w_rd  = w_instr[11:7];
                w_rs1 = w_instr[19:15];
                w_imm = w_imm_i;
            end
            7'd99: begin
                case (w_f3)
                    3'd0:    w_op = ID_BEQ;
                    3'd1:    w_op = ID_BNE;
                    3'd4:    w_op = ID_BLT;
                    3'd5:    w_op = ID_BGE;
                    3'd6:    w_op = ID_BLTU;
                    3'd7:    w_op = ID_BGEU;
                    default: w_op = '0;
                endcase
                w_rs  = 1'b1;
                w_rs1 = w_instr[19:15];
                w_rs2 = w_instr[24:20];
                w_imm = w_imm_b;
            end
            7'd3: begin
                case (w_f3)
                    3'd0:    w_op = ID_LB;
                    3'd1:    w_op = ID_LH;
                    3'd2:    w_op = ID_LW;
                    3'd4:    w_op = ID_LBU;
                    3'd5:    w_op = ID_LHU;
                    default: w_op = '0;
                endcase
                w_lsb = 1'b1;
                w_rd  = w_instr[11:7];
                w_rs1 = w_instr[19:15];
                w_imm = w_imm_i;
            end
            7'd35: begin
                case (w_f3)
                    3'd0:    w_op = ID_SB;
                    3'd1:    w_op = ID_SH;
                    3'd2:    w_op = ID_SW;
                    default: w_op = '0;
                endcase
                w_lsb = 1'b1;
                w_rs1 = w_instr[19:15];
                w_rs2 = w_instr[24:20];
                w_imm = w_imm_s;
            end
            7'd19: begin
                w_rs  = 1'b1;
                w_rd  = w_instr[11:7];
                w_rs1 = w_instr[19:15];
                w_imm = w_imm_i;
                case (w_f3)
                    3'd0: w_op = ID_ADDI;
                    3'd2: w_op = ID_SLTI;
                    3'd3: w_op = ID_SLTIU;
                    3'd4: w_op = ID_XORI;
                    3'd6: w_op = ID_ORI;
                    3'd7: w_op = ID_ANDI;
                    3'd1: begin
                        w_imm = w_imm_sh;
                        if (w_f7 == 7'b0000000) w_op = ID_SLLI;
                    end
                    3'd5: begin
                        w_imm = w_imm_sh;
                        if (w_f7 == 7'b0000000)
                            w_op = ID_SRLI;
                        else if (w_f7 == 7'b0100000)
                            w_op = ID_SRAI;
                    end
                endcase
            end
            7'd51: begin
                w_rs  = 1'b1;
                w_rd  = w_instr[11:7];
                w_rs1 = w_instr[19:15];
                w_rs2 = w_instr[24:20];
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'd0: w_op = ID_ADD;
                        3'd1: w_op = ID_SLL;
                        3'd2: w_op = ID_SLT;
                        3'd3: w_op = ID_SLTU;
                        3'd4: w_op = ID_XOR;
                        3'd5: w_op = ID_SRL;
                        3'd6: w_op = ID_OR;
                        3'd7: w_op = ID_AND;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    if (w_f3 == 3'd0)
                        w_op = ID_SUB;
                    else if (w_f3 == 3'd5)
                        w_op = ID_SRA;
                end
`ifdef DECODE_RV32M_EN
                else if (w_f7 == 7'b0000001) begin
                    w_op = ID_MUL + {3'b000, w_f3};
                end
`endif
            end
            default: w_op = '0;
        endcase
        // Undecodable entries carry no operands; commit traps on them.
        if (w_op == '0) begin
            w_rs  = 1'b0;
            w_lsb = 1'b0;
            w_rd  = '0;
            w_rs1 = '0;
            w_rs2 = '0;
            w_imm = '0;
        end
    end

    always_comb begin
        dsp_to_rs     = 1'b0;
        dsp_to_lsb    = 1'b0;
        dsp_illegal   = 1'b0;
        dsp_opcode_id = '0;
        dsp_rd        = '0;
        dsp_rs1       = '0;
        dsp_rs2       = '0;
        dsp_imm       = '0;
        dsp_isjump    = 1'b0;
        dsp_jump_pc   = '0;
        if (w_nonempty) begin
            dsp_to_rs     = w_rs;
            dsp_to_lsb    = w_lsb;
            dsp_illegal   = (w_op == '0);
            dsp_opcode_id = w_op;
            dsp_rd        = w_rd;
            dsp_rs1       = w_rs1;
            dsp_rs2       = w_rs2;
            dsp_imm       = w_imm;
            dsp_isjump    = r_isjump[r_rd_ptr];
            dsp_jump_pc   = r_jpc[r_rd_ptr];
        end
    end

    assign dsp_valid = w_nonempty && rdy && !rob_full
                    && !(w_lsb && lsb_full)
                    && !(w_rs && rs_full)
                    && !jump_wrong;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr]  <= in_instr;
            r_isjump[r_wr_ptr] <= in_isjump;
            r_jpc[r_wr_ptr]    <= in_jump_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (rdy) begin
            if (jump_wrong) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PONE;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CONE;
                    2'b01:   r_count <= r_count - CONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: a queue of expected head entries is
// pushed on accepted fetches and compared against the dispatch outputs.
module tb_decode_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int NT    = 13;

    logic        clk = 1'b0;
    logic        rst_n, rdy, jump_wrong;
    logic        in_valid, in_ready, in_isjump;
    logic [31:0] in_instr, in_jump_pc;
    logic        rob_full, rs_full, lsb_full;
    logic        dsp_valid, dsp_to_rs, dsp_to_lsb, dsp_illegal;
    logic [5:0]  dsp_opcode_id;
    logic [4:0]  dsp_rd, dsp_rs1, dsp_rs2;
    logic [31:0] dsp_imm, dsp_jump_pc;
    logic        dsp_isjump;
    logic [AW:0] count;

    typedef struct {
        logic [31:0] instr;
        logic        isj;
        logic [31:0] jpc;
        logic [5:0]  op;
        logic        rs;
        logic        lsb;
        logic        ill;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } exp_t;

    exp_t tbl [NT];
    exp_t sb [$];
    exp_t offer;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .jump_wrong(jump_wrong),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_isjump(in_isjump),
        .in_jump_pc(in_jump_pc),
        .rob_full(rob_full), .rs_full(rs_full),
        .lsb_full(lsb_full),
        .dsp_valid(dsp_valid), .dsp_to_rs(dsp_to_rs),
        .dsp_to_lsb(dsp_to_lsb), .dsp_illegal(dsp_illegal),
        .dsp_opcode_id(dsp_opcode_id),
        .dsp_rd(dsp_rd), .dsp_rs1(dsp_rs1), .dsp_rs2(dsp_rs2),
        .dsp_imm(dsp_imm), .dsp_isjump(dsp_isjump),
        .dsp_jump_pc(dsp_jump_pc), .count(count)
    );

    function automatic exp_t mk(
        input logic [31:0] instr, input logic [5:0] op,
        input logic rs, input logic lsb,
        input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [31:0] imm);
        exp_t e;
        e.instr = instr; e.isj = 1'b0; e.jpc = '0;
        e.op = op; e.rs = rs; e.lsb = lsb;
        e.ill = (op == 6'd0);
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        return e;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic offer_k(input int k);
        offer      = tbl[k];
        offer.isj  = 1'($urandom_range(0, 1));
        offer.jpc  = $urandom;
        in_valid   = 1'b1;
        in_instr   = offer.instr;
        in_isjump  = offer.isj;
        in_jump_pc = offer.jpc;
    endtask

    task automatic tick();
        exp_t h;
        logic er, ev;
        #1;
        er = (sb.size() != DEPTH);
        ev = 1'b0;
        if (sb.size() != 0) begin
            h  = sb[0];
            ev = rdy && !rob_full && !(h.lsb && lsb_full)
              && !(h.rs && rs_full) && !jump_wrong;
        end
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("count", 32'(count), 32'(sb.size()));
        chk("dsp_valid", 32'(dsp_valid), 32'(ev));
        if (sb.size() != 0) begin
            chk("opcode_id", 32'(dsp_opcode_id), 32'(h.op));
            chk("to_rs", 32'(dsp_to_rs), 32'(h.rs));
            chk("to_lsb", 32'(dsp_to_lsb), 32'(h.lsb));
            chk("illegal", 32'(dsp_illegal), 32'(h.ill));
            chk("rd", 32'(dsp_rd), 32'(h.rd));
            chk("rs1", 32'(dsp_rs1), 32'(h.rs1));
            chk("rs2", 32'(dsp_rs2), 32'(h.rs2));
            chk("imm", dsp_imm, h.imm);
            chk("isjump", 32'(dsp_isjump), 32'(h.isj));
            chk("jump_pc", dsp_jump_pc, h.jpc);
        end else begin
            chk("empty_op", 32'(dsp_opcode_id), 32'd0);
            chk("empty_imm", dsp_imm, 32'd0);
            chk("empty_ill", 32'(dsp_illegal), 32'd0);
            chk("empty_jpc", dsp_jump_pc, 32'd0);
            chk("empty_rd", 32'(dsp_rd), 32'd0);
        end
        if (rdy) begin
            if (jump_wrong) begin
                sb.delete();
            end else begin
                if (ev) void'(sb.pop_front());
                if (in_valid && er) sb.push_back(offer);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(32'h00500093, 6'd19, 1, 0, 1, 0, 0, 32'd5);
        tbl[1]  = mk(32'h0021A223, 6'd18, 0, 1, 0, 3, 2, 32'd4);
`ifdef DECODE_RV32M_EN
        tbl[2]  = mk(32'h027302B3, 6'd40, 1, 0, 5, 6, 7, 32'd0);
`else
        tbl[2]  = mk(32'h027302B3, 6'd0, 0, 0, 0, 0, 0, 32'd0);
`endif
        tbl[3]  = mk(32'h12345537, 6'd1, 0, 0, 10, 0, 0,
                     32'h12345000);
        tbl[4]  = mk(32'hFFDFF0EF, 6'd3, 0, 0, 1, 0, 0,
                     32'hFFFFFFFC);
        tbl[5]  = mk(32'h00208463, 6'd5, 1, 0, 0, 1, 2, 32'd8);
        tbl[6]  = mk(32'hFF82A203, 6'd13, 0, 1, 4, 5, 0,
                     32'hFFFFFFF8);
        tbl[7]  = mk(32'h402081B3, 6'd29, 1, 0, 3, 1, 2, 32'd0);
        tbl[8]  = mk(32'h41F3D313, 6'd27, 1, 0, 6, 7, 0, 32'd31);
        tbl[9]  = mk(32'h0000007F, 6'd0, 0, 0, 0, 0, 0, 32'd0);
        tbl[10] = mk(32'h0020A463, 6'd0, 0, 0, 0, 0, 0, 32'd0);
        tbl[11] = mk(32'h00001397, 6'd2, 0, 0, 7, 0, 0,
                     32'h00001000);
        tbl[12] = mk(32'h00008067, 6'd4, 1, 0, 0, 1, 0, 32'd0);

        rst_n = 1'b0; rdy = 1'b1; jump_wrong = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_isjump = 1'b0;
        in_jump_pc = '0; rob_full = 1'b0; rs_full = 1'b0;
        lsb_full = 1'b0;
        offer = tbl[0];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dsp_valid", 32'(dsp_valid), 32'd0);
        chk("rst_opcode", 32'(dsp_opcode_id), 32'd0);
        chk("rst_imm", dsp_imm, 32'd0);
        rst_n = 1'b1;

        // single ADDI, one-cycle latency
        offer_k(0); tick();
        in_valid = 1'b0; tick(); tick();

        // fill to DEPTH behind rob_full, then drain in order
        rob_full = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            offer_k(i % NT); tick();
        end
        in_valid = 1'b0; tick();
        rob_full = 1'b0;
        repeat (DEPTH + 1) tick();

        // store held by lsb_full, then addi held by rs_full
        lsb_full = 1'b1;
        offer_k(1); tick();
        in_valid = 1'b0; repeat (3) tick();
        lsb_full = 1'b0; tick(); tick();
        rs_full = 1'b1;
        offer_k(0); tick();
        offer_k(3); tick();
        in_valid = 1'b0; tick();
        rs_full = 1'b0; repeat (3) tick();

        // flush with 5 entries and a same-cycle push
        rob_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer_k(i + 4); tick();
        end
        offer_k(12); jump_wrong = 1'b1; tick();
        jump_wrong = 1'b0; in_valid = 1'b0; rob_full = 1'b0;
        tick(); tick();

        // steady push+pop across pointer wrap
        rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer_k(i + 5); tick();
        end
        rob_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            offer_k(i % NT); tick();
        end
        in_valid = 1'b0; repeat (4) tick();

        // rdy=0 freezes state and defers the flush
        rob_full = 1'b1;
        offer_k(6); tick();
        offer_k(7); tick();
        rdy = 1'b0; rob_full = 1'b0; jump_wrong = 1'b1;
        offer_k(8); tick(); tick();
        jump_wrong = 1'b0; tick();
        rdy = 1'b1; in_valid = 1'b0; repeat (3) tick();

        // MUL decode, then asynchronous reset mid-stream
        rob_full = 1'b1;
        offer_k(2); tick();
        offer_k(0); tick();
        offer_k(4); tick();
        in_valid = 1'b0; tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        chk("async_rst_op", 32'(dsp_opcode_id), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1; rob_full = 1'b0;
        tick();
        offer_k(11); tick();
        in_valid = 1'b0; tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
